// File: rtl/referee_merge_pkg.sv
// Shared definitions for the referee merge path.
//   LINE_SIZE   : width of one FIFO word {class[1:0], dest[1:0], data[7:0]}
//   CLASS_BITS  : width of the class field / grant index
//   NUM_CLASSES : number of per-class input FIFOs (only 4 supported)
//   state_t     : merge FSM encoding (IDLE / POP / PUSH)
//   class_slice : selects one class word out of the packed data_in bus
package referee_pkg;

  localparam int LINE_SIZE   = 12;
  localparam int CLASS_BITS  = 2;
  localparam int NUM_CLASSES = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    POP  = 2'd1,
    PUSH = 2'd2
  } state_t;

  // Constant-index mux so every slice is a fixed part-select.
  function automatic logic [LINE_SIZE-1:0] class_slice(
    input logic [NUM_CLASSES*LINE_SIZE-1:0] bus,
    input logic [CLASS_BITS-1:0]            cls
  );
    logic [LINE_SIZE-1:0] r;
    r = '0;
    for (int i = 0; i < NUM_CLASSES; i++) begin
      if (cls == CLASS_BITS'(i)) r = bus[i*LINE_SIZE +: LINE_SIZE];
    end
    return r;
  endfunction

endpackage

// File: rtl/referee_merge_rr_arbiter_4.sv
// 4-way arbiter for the referee merge path.
// Build option: REFEREE_MERGE_STRICT_PRIO_EN selects fixed priority
// (class 0 highest); otherwise round-robin starting after the last winner.
// Ports:
//   clk, reset   : clock, asynchronous active-high reset
//   req          : per-class request
//   advance      : a grant is being taken this cycle; move the pointer
//   grant_onehot : one-hot winner (zero when no request)
//   grant_idx    : winner index
//   any_req      : at least one request present
//   last         : round-robin pointer (last winner), reset to 3
module rr_arbiter_4
  import referee_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic [3:0]            req,
  input  logic                  advance,
  output logic [3:0]            grant_onehot,
  output logic [CLASS_BITS-1:0] grant_idx,
  output logic                  any_req,
  output logic [CLASS_BITS-1:0] last
);

  logic [CLASS_BITS-1:0] cand;
  logic                  found;

  always_comb begin
    any_req   = |req;
    grant_idx = '0;
    cand      = '0;
    found     = 1'b0;
`ifdef REFEREE_MERGE_STRICT_PRIO_EN
    // Lowest index wins; pointer is kept but ignored.
    for (int i = 0; i < 4; i++) begin
      cand = CLASS_BITS'(i);
      if (!found && req[cand]) begin
        grant_idx = cand;
        found     = 1'b1;
      end
    end
`else
    // Search last+1 .. last+4 (mod 4); last itself is checked last.
    for (int k = 1; k <= 4; k++) begin
      cand = last + CLASS_BITS'(k);
      if (!found && req[cand]) begin
        grant_idx = cand;
        found     = 1'b1;
      end
    end
`endif
    grant_onehot = any_req ? (4'b0001 << grant_idx) : 4'b0000;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)        last <= 2'd3;
    else if (advance) last <= grant_idx;
  end

endmodule

// File: rtl/referee_merge.sv
// referee_merge: drains four per-class FIFOs into one egress FIFO.
// A granted class gets a one-cycle pop; its read data is captured the next
// cycle and pushed unchanged to the egress FIFO. Re-arbitration happens in
// the push cycle, so pop and push of different words may overlap.
// Build option: REFEREE_MERGE_STRICT_PRIO_EN (fixed priority, class 0 first).
// Handshake: pop_signal is a one-hot single-cycle strobe issued only when the
//   class is not almost-empty and the egress is not almost-full; the popped
//   word is valid on data_in the following cycle; push_signal is a
//   single-cycle strobe with data_out valid in that cycle.
// Ports:
//   clk, reset          : clock, asynchronous active-high reset
//   data_in             : class FIFO read data, class i at [i*LINE_SIZE +: LINE_SIZE]
//   almost_empty_signal : per-class almost-empty (1 = not eligible)
//   almost_full_signal  : egress almost-full (blocks new grants)
//   pop_signal          : one-hot pop pulse to the class FIFOs
//   push_signal         : push pulse to the egress FIFO
//   data_out            : word pushed to the egress FIFO
//   grant_class         : class of the most recent grant
//   state_dbg           : current FSM state
module referee_merge
  import referee_pkg::*;
(
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_CLASSES*LINE_SIZE-1:0] data_in,
  input  logic [NUM_CLASSES-1:0]           almost_empty_signal,
  input  logic                             almost_full_signal,
  output logic [NUM_CLASSES-1:0]           pop_signal,
  output logic                             push_signal,
  output logic [LINE_SIZE-1:0]             data_out,
  output logic [CLASS_BITS-1:0]            grant_class,
  output state_t                           state_dbg
);

  state_t                  state, state_nxt;
  logic [NUM_CLASSES-1:0]  pop_nxt;
  logic                    push_nxt;
  logic [LINE_SIZE-1:0]    data_nxt;
  logic [CLASS_BITS-1:0]   grant_nxt;

  logic [NUM_CLASSES-1:0]  req;
  logic [NUM_CLASSES-1:0]  grant_onehot;
  logic [CLASS_BITS-1:0]   grant_idx;
  logic [CLASS_BITS-1:0]   rr_last;
  logic                    any_req;
  logic                    advance;

  assign req       = ~almost_empty_signal & {NUM_CLASSES{~almost_full_signal}};
  assign state_dbg = state;

  rr_arbiter_4 u_arb (
    .clk          (clk),
    .reset        (reset),
    .req          (req),
    .advance      (advance),
    .grant_onehot (grant_onehot),
    .grant_idx    (grant_idx),
    .any_req      (any_req),
    .last         (rr_last)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      pop_signal  <= '0;
      push_signal <= 1'b0;
      data_out    <= '0;
      grant_class <= '0;
    end else begin
      state       <= state_nxt;
      pop_signal  <= pop_nxt;
      push_signal <= push_nxt;
      data_out    <= data_nxt;
      grant_class <= grant_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pop_nxt   = '0;
    push_nxt  = 1'b0;
    data_nxt  = data_out;
    grant_nxt = grant_class;
    advance   = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) begin
          pop_nxt   = grant_onehot;
          grant_nxt = grant_idx;
          advance   = 1'b1;
          state_nxt = POP;
        end
      end
      POP: begin
        state_nxt = PUSH;
      end
      PUSH: begin
        // grant_class still names the in-flight word here; the new grant
        // (if any) only lands in grant_class at the end of this cycle.
        data_nxt = class_slice(data_in, grant_class);
        push_nxt = 1'b1;
        if (any_req) begin
          pop_nxt   = grant_onehot;
          grant_nxt = grant_idx;
          advance   = 1'b1;
          state_nxt = POP;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_referee_merge.sv
module tb_referee_merge;
  import referee_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [NUM_CLASSES*LINE_SIZE-1:0] data_in;
  logic [3:0]  almost_empty_signal;
  logic        almost_full_signal;
  logic [3:0]  pop_signal;
  logic        push_signal;
  logic [11:0] data_out;
  logic [1:0]  grant_class;
  state_t      state_dbg;

  referee_merge dut (
    .clk                 (clk),
    .reset               (reset),
    .data_in             (data_in),
    .almost_empty_signal (almost_empty_signal),
    .almost_full_signal  (almost_full_signal),
    .pop_signal          (pop_signal),
    .push_signal         (push_signal),
    .data_out            (data_out),
    .grant_class         (grant_class),
    .state_dbg           (state_dbg)
  );

  // ---------------- environment: four class FIFOs ----------------
  logic [11:0] fmem [4][16];
  int          fhead [4];
  int          fcnt  [4];
  logic [11:0] rd_reg [4];
  logic [3:0]  force_ae;

  // ---------------- scoreboard ----------------
  logic [11:0] exp_q[$];
  int          due_q[$];
  logic [3:0]  exp_pop   = '0;
  logic [1:0]  exp_grant = '0;
  int          m_last    = 3;
  int          cooldown  = 0;
  int          cyc       = 0;
  int          n_checks  = 0;
  int          n_fail    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic refresh();
    for (int i = 0; i < 4; i++) begin
      almost_empty_signal[i] = (fcnt[i] == 0) | force_ae[i];
      data_in[i*12 +: 12]    = rd_reg[i];
    end
  endtask

  task automatic push_word(input int cls, input logic [11:0] w);
    if (fcnt[cls] < 16) begin
      fmem[cls][(fhead[cls] + fcnt[cls]) % 16] = w;
      fcnt[cls]++;
    end
  endtask

  function automatic logic [11:0] rand_word(input int cls);
    logic [1:0] c;
    c = 2'(cls);
    return {c, 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255))};
  endfunction

  // A FIFO acts on the pop seen in this cycle: the head moves to its read
  // register, which is what data_in shows from the next cycle on.
  task automatic tick();
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      if (pop_signal[i] && fcnt[i] > 0) begin
        rd_reg[i] = fmem[i][fhead[i]];
        fhead[i]  = (fhead[i] + 1) % 16;
        fcnt[i]--;
      end
    end
    refresh();
  endtask

  // ---------------- reference model ----------------
  // One grant may be taken per arbitration opportunity; after a grant the
  // next opportunity is two cycles later. The granted word is the FIFO head
  // and must appear at the egress two cycles after its pop.
  initial forever begin
    int g;
    int c;
    @(posedge clk or posedge reset);
    if (reset) begin
      m_last    = 3;
      cooldown  = 0;
      exp_pop   = '0;
      exp_grant = '0;
      exp_q.delete();
      due_q.delete();
    end else begin
      cyc++;
      exp_pop = '0;
      if (cooldown > 0) begin
        cooldown--;
      end else begin
        g = -1;
        for (int k = 0; k < 4; k++) begin
`ifdef REFEREE_MERGE_STRICT_PRIO_EN
          c = k;
`else
          c = (m_last + 1 + k) % 4;
`endif
          if (g < 0 && !almost_empty_signal[c] && !almost_full_signal) g = c;
        end
        if (g >= 0) begin
          exp_pop   = 4'(1 << g);
          exp_grant = 2'(g);
          m_last    = g;
          exp_q.push_back(fmem[g][fhead[g]]);
          due_q.push_back(cyc + 2);
          cooldown  = 1;
        end
      end
    end
  end

  // ---------------- monitor ----------------
  initial forever begin
    logic exp_push;
    @(negedge clk);
    if (!reset) begin
      chk("pop", 32'(pop_signal), 32'(exp_pop));
      chk("grant_class", 32'(grant_class), 32'(exp_grant));
      exp_push = (due_q.size() > 0) && (due_q[0] == cyc);
      chk("push", 32'(push_signal), 32'(exp_push));
      if (push_signal && exp_push) begin
        chk("data_out", 32'(data_out), 32'(exp_q[0]));
        void'(exp_q.pop_front());
        void'(due_q.pop_front());
      end else if (due_q.size() > 0 && due_q[0] <= cyc) begin
        void'(exp_q.pop_front());
        void'(due_q.pop_front());
      end
    end
  end

  // ---------------- driver ----------------
  initial begin
    int guard;
    reset              = 1'b1;
    almost_full_signal = 1'b0;
    force_ae           = '0;
    data_in            = '0;
    for (int i = 0; i < 4; i++) begin
      fhead[i]  = 0;
      fcnt[i]   = 0;
      rd_reg[i] = '0;
    end
    refresh();

    // Reset state
    tick();
    #1;
    chk("rst_pop", 32'(pop_signal), 32'h0);
    chk("rst_push", 32'(push_signal), 32'h0);
    chk("rst_data", 32'(data_out), 32'h0);
    chk("rst_grant", 32'(grant_class), 32'h0);

    // Single class 2 word
    push_word(2, 12'hA5C);
    refresh();
    tick();
    reset = 1'b0;
    repeat (8) tick();

    // All classes loaded, back-to-back service
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 3; j++) push_word(i, rand_word(i));
    refresh();
    repeat (30) tick();

    // Egress almost-full with everything loaded
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 3; j++) push_word(i, rand_word(i));
    almost_full_signal = 1'b1;
    refresh();
    repeat (10) tick();
    almost_full_signal = 1'b0;
    guard = 0;
    while (pop_signal == 4'b0 && guard < 20) begin
      tick();
      guard++;
    end
    chk("af_pop_seen", 32'(guard < 20), 32'h1);
    almost_full_signal = 1'b1;  // raised during the pop cycle
    repeat (8) tick();
    almost_full_signal = 1'b0;
    refresh();

    // Class 1 goes almost-empty right after its pop
    for (int i = 1; i < 3; i++)
      for (int j = 0; j < 3; j++) push_word(i, rand_word(i));
    refresh();
    guard = 0;
    while (pop_signal != 4'b0010 && guard < 40) begin
      tick();
      guard++;
    end
    chk("ae_pop1_seen", 32'(guard < 40), 32'h1);
    force_ae[1] = 1'b1;
    refresh();
    repeat (8) tick();
    force_ae = '0;
    refresh();

    // Reset while in POP
    for (int i = 0; i < 4; i++) push_word(i, rand_word(i));
    refresh();
    guard = 0;
    while (pop_signal == 4'b0 && guard < 20) begin
      tick();
      guard++;
    end
    chk("rst_pop_seen", 32'(guard < 20), 32'h1);
    #2 reset = 1'b1;
    #1;
    chk("arst_pop", 32'(pop_signal), 32'h0);
    chk("arst_push", 32'(push_signal), 32'h0);
    chk("arst_data", 32'(data_out), 32'h0);
    chk("arst_grant", 32'(grant_class), 32'h0);
    tick();
    tick();
    reset = 1'b0;
    push_word(0, rand_word(0));
    for (int j = 0; j < 6; j++) push_word(0, rand_word(0));
    for (int j = 0; j < 3; j++) push_word(3, rand_word(3));
    refresh();
    repeat (30) tick();

    // Random traffic
    for (int n = 0; n < 1500; n++) begin
      tick();
      if ($urandom_range(0, 9) < 3) begin
        int c;
        c = $urandom_range(0, 3);
        if (fcnt[c] < 6) push_word(c, rand_word(c));
      end
      almost_full_signal = ($urandom_range(0, 9) == 0);
      for (int i = 0; i < 4; i++) force_ae[i] = ($urandom_range(0, 9) == 0);
      refresh();
    end

    // Drain in-flight words and confirm nothing is outstanding
    almost_full_signal = 1'b1;
    force_ae = '0;
    refresh();
    repeat (6) tick();
    chk("drain", 32'(exp_q.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
